// File: rtl/cb_arb_pkg.sv
// Shared definitions for the write arbiter: state encodings and a width helper.
package cb_arb_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_OWN  = 1'b1;

  // Ceiling log2, never below 1 so a counter or index always has at least one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v * 2) begin
      r++;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/cb_dff_en_vec.sv
// Clock-enabled register bank holding the single shared value.
module cb_dff_en_vec #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg <= '0;
    end else if (en) begin
      q_reg <= d;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/cb_dff_write_arbiter.sv
// Round-robin arbiter granting bounded write bursts into one shared clock-enabled register.
module cb_dff_write_arbiter
  import cb_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       grant,
  output logic                  en_out,
  output logic [WIDTH-1:0]      d_out,
  output logic [WIDTH-1:0]      q,
  output logic                  busy
);

  localparam int PW = clog2(NREQ);
  localparam int CW = clog2(MAX_BURST);

  logic             state_reg;
  logic [PW-1:0]    ptr_reg;
  logic [PW-1:0]    owner_reg;
  logic [CW-1:0]    cnt_reg;
  logic [NREQ-1:0]  grant_reg;

  logic [WIDTH-1:0] wdata_arr [NREQ];
  logic [PW-1:0]    cand_idx  [NREQ];
  logic [NREQ-1:0]  rot_req;
  logic [PW-1:0]    winner;
  logic [PW-1:0]    next_ptr;
  logic             last_write;

  // cand_idx[k] is the requester examined k places after ptr in the rotation.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
      assign wdata_arr[gi] = wdata[gi*WIDTH +: WIDTH];
      assign cand_idx[gi]  = PW'((int'(ptr_reg) + gi) % NREQ);
      assign rot_req[gi]   = req[cand_idx[gi]];
    end
  endgenerate

  // Scan from the far end so the requester closest to ptr overrides the rest.
  always_comb begin
    winner = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot_req[k]) begin
        winner = cand_idx[k];
      end
    end
  end

  assign next_ptr   = (owner_reg == PW'(NREQ - 1)) ? '0 : PW'(owner_reg + 1'b1);
  assign last_write = (cnt_reg == CW'(MAX_BURST - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      ptr_reg   <= '0;
      owner_reg <= '0;
      cnt_reg   <= '0;
      grant_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (|req) begin
            owner_reg <= winner;
            grant_reg <= {{(NREQ-1){1'b0}}, 1'b1} << winner;
            cnt_reg   <= '0;
            state_reg <= ST_OWN;
          end
        end
        ST_OWN: begin
          if (req[owner_reg]) begin
            cnt_reg <= cnt_reg + 1'b1;
            if (last_write) begin
              state_reg <= ST_IDLE;
              grant_reg <= '0;
              ptr_reg   <= next_ptr;
            end
          end else begin
            // Owner released early: hand the turn on without a write.
            state_reg <= ST_IDLE;
            grant_reg <= '0;
            ptr_reg   <= next_ptr;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          grant_reg <= '0;
        end
      endcase
    end
  end

  assign en_out = (state_reg == ST_OWN) && req[owner_reg];
  assign d_out  = en_out ? wdata_arr[owner_reg] : '0;
  assign busy   = (state_reg == ST_OWN);
  assign grant  = grant_reg;

  cb_dff_en_vec #(
    .WIDTH (WIDTH)
  ) u_reg (
    .clk (clk),
    .rst (rst),
    .en  (en_out),
    .d   (d_out),
    .q   (q)
  );

endmodule

// File: tb/tb_cb_dff_write_arbiter.sv
// Directed table-driven bench for the round-robin write arbiter (NREQ=4, WIDTH=8, MAX_BURST=4).
module tb_cb_dff_write_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] wdata;
  logic [3:0]  grant;
  logic        en_out;
  logic [7:0]  d_out;
  logic [7:0]  q;
  logic        busy;

  cb_dff_write_arbiter #(
    .NREQ      (4),
    .WIDTH     (8),
    .MAX_BURST (4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .wdata  (wdata),
    .grant  (grant),
    .en_out (en_out),
    .d_out  (d_out),
    .q      (q),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [31:0] wdata;
    logic [3:0]  grant;
    logic        en;
    logic [7:0]  d;
    logic [7:0]  q;
    logic        busy;
  } vec_t;

  vec_t vecs[$];
  int   checks;
  int   passed;

  task automatic add(input logic r, input logic [3:0] rq, input logic [31:0] wd,
                     input logic [3:0] g, input logic e, input logic [7:0] dd,
                     input logic [7:0] qq, input logic b);
    vec_t v;
    v.rst = r; v.req = rq; v.wdata = wd;
    v.grant = g; v.en = e; v.d = dd; v.q = qq; v.busy = b;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int row, input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got !== want) begin
      $display("FAIL %s row=%0d got=%h want=%h", name, row, got, want);
    end else begin
      passed++;
    end
  endtask

  task automatic check_all(input string tag, input int row, input logic [3:0] g,
                           input logic e, input logic [7:0] dd, input logic [7:0] qq,
                           input logic b);
    check({tag, "_grant"}, row, 32'(grant), 32'(g));
    check({tag, "_en"},    row, 32'(en_out), 32'(e));
    check({tag, "_d"},     row, 32'(d_out), 32'(dd));
    check({tag, "_q"},     row, 32'(q), 32'(qq));
    check({tag, "_busy"},  row, 32'(busy), 32'(b));
    $display("%s row=%0d rst=%b req=%b grant=%b en=%b d=%h q=%h busy=%b",
             tag, row, rst, req, grant, en_out, d_out, q, busy);
  endtask

  localparam logic [31:0] W = 32'h1312_1110;
  localparam logic [31:0] A = 32'h00A5_0000;
  localparam logic [31:0] B = 32'h0000_003C;

  initial begin
    logic [7:0] q_exp;
    checks = 0;
    passed = 0;
    rst    = 1'b1;
    req    = 4'hF;
    wdata  = W;

    // Reset held with every request asserted.
    repeat (3) add(1'b1, 4'hF, W, 4'h0, 1'b0, 8'h00, 8'h00, 1'b0);

    // Full rotation from ptr=0: idle bubble, then four writes per owner.
    q_exp = 8'h00;
    for (int o = 0; o < 4; o++) begin
      add(1'b0, 4'hF, W, 4'h0, 1'b0, 8'h00, q_exp, 1'b0);
      for (int b = 0; b < 4; b++) begin
        add(1'b0, 4'hF, W, 4'(1 << o), 1'b1, 8'(8'h10 + o), q_exp, 1'b1);
        q_exp = 8'(8'h10 + o);
      end
    end
    add(1'b0, 4'hF, W, 4'h0, 1'b0, 8'h00, 8'h13, 1'b0);
    for (int b = 0; b < 4; b++) begin
      add(1'b0, 4'hF, W, 4'b0001, 1'b1, 8'h10, q_exp, 1'b1);
      q_exp = 8'h10;
    end

    // Owner 1 writes once then drops; requester 3 is granted two edges later.
    add(1'b0, 4'hF,    W, 4'h0,    1'b0, 8'h00, 8'h10, 1'b0);
    add(1'b0, 4'hF,    W, 4'b0010, 1'b1, 8'h11, 8'h10, 1'b1);
    add(1'b0, 4'b1000, W, 4'b0010, 1'b0, 8'h00, 8'h11, 1'b1);
    add(1'b0, 4'b1000, W, 4'h0,    1'b0, 8'h00, 8'h11, 1'b0);
    add(1'b0, 4'b1000, W, 4'b1000, 1'b1, 8'h13, 8'h11, 1'b1);
    add(1'b0, 4'h0,    W, 4'b1000, 1'b0, 8'h00, 8'h13, 1'b1);

    // Lone requester 2 writes A5 twice, leaving ptr=3.
    add(1'b0, 4'b0100, A, 4'h0,    1'b0, 8'h00, 8'h13, 1'b0);
    add(1'b0, 4'b0100, A, 4'b0100, 1'b1, 8'hA5, 8'h13, 1'b1);
    add(1'b0, 4'b0100, A, 4'b0100, 1'b1, 8'hA5, 8'hA5, 1'b1);
    add(1'b0, 4'h0,    A, 4'b0100, 1'b0, 8'h00, 8'hA5, 1'b1);
    add(1'b0, 4'h0,    A, 4'h0,    1'b0, 8'h00, 8'hA5, 1'b0);

    // Wrap from ptr=3 to requester 0, then all requesters prove ptr=1.
    add(1'b0, 4'b0001, B, 4'h0,    1'b0, 8'h00, 8'hA5, 1'b0);
    add(1'b0, 4'b0001, B, 4'b0001, 1'b1, 8'h3C, 8'hA5, 1'b1);
    add(1'b0, 4'h0,    B, 4'b0001, 1'b0, 8'h00, 8'h3C, 1'b1);
    add(1'b0, 4'hF,    W, 4'h0,    1'b0, 8'h00, 8'h3C, 1'b0);
    add(1'b0, 4'hF,    W, 4'b0010, 1'b1, 8'h11, 8'h3C, 1'b1);
    add(1'b0, 4'h0,    W, 4'b0010, 1'b0, 8'h00, 8'h11, 1'b1);
    add(1'b0, 4'h0,    W, 4'h0,    1'b0, 8'h00, 8'h11, 1'b0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst   = vecs[i].rst;
      req   = vecs[i].req;
      wdata = vecs[i].wdata;
      #1;
      check_all("vec", i, vecs[i].grant, vecs[i].en, vecs[i].d, vecs[i].q, vecs[i].busy);
    end

    // Asynchronous reset mid-burst (ptr=2, owner 1, cnt=2).
    @(negedge clk);
    req   = 4'b0010;
    wdata = 32'h0000_7700;
    #1 check_all("rstmid", 0, 4'h0, 1'b0, 8'h00, 8'h11, 1'b0);
    @(negedge clk);
    #1 check_all("rstmid", 1, 4'b0010, 1'b1, 8'h77, 8'h11, 1'b1);
    @(negedge clk);
    #1 check_all("rstmid", 2, 4'b0010, 1'b1, 8'h77, 8'h77, 1'b1);
    @(negedge clk);
    #1 check_all("rstmid", 3, 4'b0010, 1'b1, 8'h77, 8'h77, 1'b1);
    #2 rst = 1'b1;
    #1 check_all("rstmid", 4, 4'h0, 1'b0, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    req = 4'b0110;
    #1 check_all("rstmid", 5, 4'h0, 1'b0, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    #1 check_all("rstmid", 6, 4'b0010, 1'b1, 8'h77, 8'h00, 1'b1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
